seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed seven-segment display driver for the digital clock. It sits directly downstream of the chain of mod-N BCD digit counters (seconds, minutes, hours). It takes their concatenated 4-bit BCD outputs, snapshots them once per frame and scans one digit at a time onto a shared segment bus. While the clock is in set mode, the digit pair selected for editing blinks.

## Interface
Parameters:
- NUM_DIGITS, 6, number of scanned digits; digit 0 = seconds units, digit 5 = hours tens
- SCAN_DIV, 1000, clk cycles per digit slot (≥2)
- BLINK_HALF, 250000, clk cycles per blink half-period (≥1)
- ACTIVE_LOW, 1, 1 = invert `seg`, `dp` and `an` at the pins (common-anode board)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- bcd_in  in  4*NUM_DIGITS  digit k at bits [4k+3:4k], fed from counter BCD_out
- set_ena  in  1  1 = set mode (blink enabled), 0 = normal run
- set_field  in  2  field being edited: 0 none, 1 digits 1:0, 2 digits 3:2, 3 digits 5:4
- seg  out  7  segments, seg[0]=a … seg[6]=g
- dp  out  1  decimal point, used as the HH.MM.SS separator
- an  out  NUM_DIGITS  digit enables, one-hot when active

## Operation
- **State:**
  - scan_cnt counts 0..SCAN_DIV-1.
  - dig counts 0..NUM_DIGITS-1.
  - blink_cnt counts 0..BLINK_HALF-1.
  - blink_on is 1 when the blinking field is visible.
  - frame is a 4*NUM_DIGITS register holding the snapshot.
- **Scan:** scan_cnt increments every cycle.
  - At SCAN_DIV-1 it wraps to 0 and dig advances by 1.
  - dig wraps from NUM_DIGITS-1 to 0.
- **Frame latch:** frame <= bcd_in on the cycle where scan_cnt==SCAN_DIV-1 and dig==NUM_DIGITS-1.
  - bcd_in changes at any other time have no effect until the next frame boundary. This prevents tearing.
- **Decode (logical, before polarity):**
  - BCD 0..9 → hex 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Codes 10..15 → 00 (blank).
- **Blink:**
  - While set_ena=0, blink_cnt is held at 0 and blink_on is held at 1.
  - While set_ena=1, blink_cnt counts and wraps at BLINK_HALF-1; blink_on toggles at each wrap.
  - When set_ena rises, blinking starts with a full visible half-period.
- **Blank condition:** a digit is blanked (seg=00, dp=0) when set_ena=1, blink_on=0, set_field≠0, and the digit is in the selected pair.
  - set_field=0 never blanks any digit.
- **Separator:** logical dp=1 on digits 2 and 4, otherwise 0. The dp is suppressed when that digit is blanked.
- **Output register:** on each edge:
  - an <= (scan_cnt==0) ? all-off : onehot(dig). This gives a 1-cycle ghosting guard at the start of every slot.
  - seg <= decode(frame digit dig), or blank if the blank condition holds.
  - dp is updated in the same way.
  - ACTIVE_LOW inversion is applied at the output register.
- **Reset:** scan_cnt=0, dig=0, blink_cnt=0, blink_on=1, frame=0. All outputs are inactive (an all-off, seg=00, dp=0 logical; all-ones at the pins when ACTIVE_LOW=1).

## Timing
- Pin outputs lag internal state by exactly 1 clk.
- Edges are numbered from 1, counting from the first edge with reset=0.
  - Edge 1: all digits off.
  - Edges 2..SCAN_DIV: digit 0 enabled.
  - Edge SCAN_DIV+1: guard (all off).
  - Edges SCAN_DIV+2..2*SCAN_DIV: digit 1 enabled, and so on.
- Frame period is NUM_DIGITS*SCAN_DIV cycles.
- Each digit is lit for SCAN_DIV-1 cycles per frame.
- A bcd_in value present on the frame-latch cycle appears on pins starting with slot 0 of the next frame.
- The first frame after reset displays 000000.
- set_ena and set_field are sampled every cycle; a change takes effect on the next registered output.
- Reset asserted mid-frame takes effect on the next edge and restores the reset values listed above. The sequence restarts at edge 1 after release.

## Test plan
Use SCAN_DIV=4, BLINK_HALF=40, NUM_DIGITS=6 and ACTIVE_LOW=0 unless noted.
- **Reset and scan order:** release reset with bcd_in=0x123456 → edge 1 an=000000; edges 2-4 an=000001, seg=3F; edge 5 an=000000; edges 6-8 an=000010. Frame period is 24 cycles.
- **Frame snapshot:** hold bcd_in=0x123456 through the first frame, then change it to 0x999999 mid-frame → the second frame shows 6,5,4,3,2,1 (seg 7D,6D,66,4F,5B,06). The third frame shows 6F on all digits.
- **Invalid code:** set digit 3 to 0xA → seg=00 during the digit-3 slot; all other digits are unaffected.
- **Blink:** set_ena=1, set_field=2 → digits 2 and 3 are visible for 40 cycles, then seg=00 and dp=0 for 40 cycles, repeating. Digits 0, 1, 4 and 5 are never blanked; digit 4 keeps dp=1. set_field=0 with set_ena=1 → no blanking.
- **Polarity:** ACTIVE_LOW=1 → during reset seg=7F, dp=1, an=111111; the digit-0 slot showing a 0 gives an=111110, seg=40.
- **Mid-operation reset:** assert reset during a blink-off phase → on the next edge outputs are inactive and blink_on=1. After release, the edge-1 sequence repeats and shows 000000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment driver with a per-frame snapshot
// and a blinking edit field for the clock's set mode.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   bcd_in     concatenated BCD digits, digit k at [4k+3:4k]
//   set_ena    1 = set mode, the selected field blinks
//   set_field  0 none, 1 digits 1:0, 2 digits 3:2, 3 digits 5:4
//   seg        segments a..g (seg[0]=a), pin polarity
//   dp         decimal point / HH.MM.SS separator, pin polarity
//   an         digit enables, one-hot when active, pin polarity
module seg7_scan_driver #(
   parameter int NUM_DIGITS = 6,
   parameter int SCAN_DIV   = 1000,
   parameter int BLINK_HALF = 250000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    set_ena,
   input  logic [1:0]              set_field,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   localparam logic POL = ACTIVE_LOW;

   // scan timing
   logic [SW-1:0] scan_q, scan_d;
   logic [DW-1:0] dig_q, dig_d;

   // blink timing
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;

   // displayed snapshot
   logic [4*NUM_DIGITS-1:0] frame_q, frame_d;

   // pin-polarity output registers
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic                  scan_wrap;
   logic                  frame_end;
   logic [3:0]            digits [NUM_DIGITS];
   logic [3:0]            cur_bcd;
   logic [31:0]           dig_idx;
   logic                  in_pair;
   logic                  blank;
   logic                  sep;
   logic [NUM_DIGITS-1:0] onehot;
   logic [NUM_DIGITS-1:0] an_log;
   logic [6:0]            seg_log;
   logic                  dp_log;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      assign digits[g] = frame_q[4*g +: 4];
   end

   assign scan_wrap = (scan_q == SCAN_LAST);
   assign frame_end = scan_wrap && (dig_q == DIG_LAST);

   always_comb begin
      scan_d  = scan_q + 1'b1;
      dig_d   = dig_q;
      frame_d = frame_q;
      if (scan_wrap) begin
         scan_d = '0;
         dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
      end
      // snapshot only at the frame boundary so a frame never tears
      if (frame_end) begin
         frame_d = bcd_in;
      end
   end

   // Held at the start of a visible half-period while not in set mode,
   // so entering set mode always begins with a full visible phase.
   always_comb begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      if (set_ena) begin
         blink_on_d = blink_on_q;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   assign cur_bcd = digits[dig_q];
   assign dig_idx = 32'(dig_q);

   // field f covers digits 2f-2 and 2f-1
   assign in_pair = (set_field != 2'd0) &&
                    ((dig_idx >> 1) == (32'(set_field) - 32'd1));
   assign blank   = set_ena && !blink_on_q && in_pair;
   assign sep     = (dig_idx == 32'd2) || (dig_idx == 32'd4);

   // first cycle of each slot is dark to hide segment changeover
   assign onehot  = NUM_DIGITS'(1) << dig_q;
   assign an_log  = (scan_q == '0) ? '0 : onehot;
   assign seg_log = blank ? 7'h00 : seg_decode(cur_bcd);
   assign dp_log  = sep && !blank;

   assign seg_d = seg_log ^ {7{POL}};
   assign dp_d  = dp_log ^ POL;
   assign an_d  = an_log ^ {NUM_DIGITS{POL}};

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_q      <= '0;
         dig_q       <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         frame_q     <= '0;
         seg_q       <= {7{POL}};
         dp_q        <= POL;
         an_q        <= {NUM_DIGITS{POL}};
      end else begin
         scan_q      <= scan_d;
         dig_q       <= dig_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         frame_q     <= frame_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed plus random stimulus against a
// cycle-count reference model, both pin polarities side by side.
module tb_seg7_scan_driver;

   localparam int ND = 6;
   localparam int SD = 4;
   localparam int BH = 40;
   localparam int FP = ND * SD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [4*ND-1:0] bcd_in;
   logic            set_ena;
   logic [1:0]      set_field;

   logic [6:0]    seg, seg_n;
   logic          dp, dp_n;
   logic [ND-1:0] an, an_n;

   seg7_scan_driver #(
      .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_HALF(BH), .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .bcd_in(bcd_in), .set_ena(set_ena),
      .set_field(set_field), .seg(seg), .dp(dp), .an(an)
   );

   seg7_scan_driver #(
      .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_HALF(BH), .ACTIVE_LOW(1'b1)
   ) dut_n (
      .clk(clk), .reset(reset), .bcd_in(bcd_in), .set_ena(set_ena),
      .set_field(set_field), .seg(seg_n), .dp(dp_n), .an(an_n)
   );

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // model state: c = edges since reset release, k = consecutive
   // set-mode edges, fr = frame on display
   int              c;
   int              k;
   logic [4*ND-1:0] fr;

   logic [6:0]    e_seg;
   logic          e_dp;
   logic [ND-1:0] e_an;

   logic [6:0] tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t",
                tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      int         ph, dg, d;
      bit         on, blank;
      logic [6:0]    i_seg;
      logic          i_dp;
      logic [ND-1:0] i_an;
      if (reset) begin
         e_an  = '0;
         e_seg = '0;
         e_dp  = 1'b0;
      end else begin
         ph    = c % SD;
         dg    = (c / SD) % ND;
         e_an  = (ph == 0) ? '0 : ND'(1) << dg;
         d     = int'((fr >> (4 * dg)) & 24'hF);
         e_seg = (d < 10) ? tab[d] : 7'h00;
         on    = ((k / BH) % 2) == 0;
         blank = set_ena && !on && set_field != 0 &&
                 (dg / 2 == int'(set_field) - 1);
         e_dp  = (dg == 2 || dg == 4) && !blank;
         if (blank) e_seg = 7'h00;
      end
      @(posedge clk);
      if (reset) begin
         c  = 0;
         k  = 0;
         fr = '0;
      end else begin
         if (c % FP == FP - 1) fr = bcd_in;
         c++;
         k = set_ena ? k + 1 : 0;
      end
      #1;
      i_seg = ~e_seg;
      i_dp  = ~e_dp;
      i_an  = ~e_an;
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
      chk("an_n", an_n, i_an);
      chk("seg_n", seg_n, i_seg);
      chk("dp_n", dp_n, i_dp);
   endtask

   initial begin
      c = 0; k = 0; fr = '0;
      reset     = 1'b1;
      bcd_in    = 24'h123456;
      set_ena   = 1'b0;
      set_field = 2'd0;
      repeat (3) step();
      chk("rst_an_n", an_n, 32'h3F);
      chk("rst_seg_n", seg_n, 32'h7F);
      chk("rst_dp_n", dp_n, 32'h1);
      chk("rst_an", an, 32'h0);
      reset = 1'b0;

      // scan order, snapshot, invalid code
      while (c < 120) begin
         if (c == 36) bcd_in = 24'h999999;
         if (c == 72) bcd_in = 24'h12A456;
         step();
         if (c == 1)  chk("e1_an", an, 32'h0);
         if (c == 2) begin
            chk("e2_an", an, 32'h1);
            chk("e2_seg", seg, 32'h3F);
            chk("e2_an_n", an_n, 32'h3E);
            chk("e2_seg_n", seg_n, 32'h40);
         end
         if (c == 4)  chk("e4_an", an, 32'h1);
         if (c == 5)  chk("e5_an", an, 32'h0);
         if (c == 6)  chk("e6_an", an, 32'h2);
         if (c == 26) chk("f2_d0", seg, 32'h7D);
         if (c == 30) chk("f2_d1", seg, 32'h6D);
         if (c == 34) begin
            chk("f2_d2", seg, 32'h66);
            chk("f2_dp2", dp, 32'h1);
         end
         if (c == 46) chk("f2_d5", seg, 32'h06);
         if (c == 50) chk("f3_d0", seg, 32'h6F);
         if (c == 70) chk("f3_d5", seg, 32'h6F);
         if (c == 106) chk("inv_d2", seg, 32'h66);
         if (c == 110) begin
            chk("inv_an", an, 32'h8);
            chk("inv_seg", seg, 32'h0);
         end
      end

      // blink on field 2
      set_ena   = 1'b1;
      set_field = 2'd2;
      while (c < 240) begin
         step();
         if (c == 130) begin
            chk("bl_vis_seg", seg, 32'h66);
            chk("bl_vis_dp", dp, 32'h1);
         end
         if (c == 178) begin
            chk("bl_off_an", an, 32'h4);
            chk("bl_off_seg", seg, 32'h0);
            chk("bl_off_dp", dp, 32'h0);
         end
         if (c == 186) begin
            chk("bl_d4_seg", seg, 32'h5B);
            chk("bl_d4_dp", dp, 32'h1);
         end
      end
      set_field = 2'd0;
      repeat (100) step();

      // random stimulus
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 29) == 0) bcd_in = 24'($urandom);
         if ($urandom_range(0, 59) == 0) set_ena = ~set_ena;
         if ($urandom_range(0, 39) == 0) set_field = 2'($urandom_range(0, 3));
         step();
      end

      // reset during a blink-off phase
      set_ena   = 1'b1;
      set_field = 2'd3;
      for (int i = 0; i < 200; i++) begin
         if ((k / BH) % 2 == 1 && k % BH > 5) break;
         step();
      end
      chk("blink_off_reached", (k / BH) % 2, 32'h1);
      reset = 1'b1;
      step();
      chk("mr_an", an, 32'h0);
      chk("mr_seg", seg, 32'h0);
      chk("mr_an_n", an_n, 32'h3F);
      reset = 1'b0;
      while (c < 30) begin
         step();
         if (c == 1) chk("mr_e1_an", an, 32'h0);
         if (c == 2) begin
            chk("mr_e2_an", an, 32'h1);
            chk("mr_e2_seg", seg, 32'h3F);
         end
         if (c == 22) begin
            chk("mr_vis_an", an, 32'h20);
            chk("mr_vis_seg", seg, 32'h3F);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
